// File: rtl/fifo2_sync.sv
// fifo2_sync: single-clock FIFO with optional first-word-fall-through read,
// occupancy count, almost-full/almost-empty thresholds and sticky error flags.
module fifo2_sync #(
   parameter int DSIZE     = 8,
   parameter int ASIZE     = 4,
   parameter int FWFT      = 0,
   parameter int AFULL_TH  = (1 << ASIZE) - 2,
   parameter int AEMPTY_TH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DSIZE-1:0] wdata,
   input  logic             winc,
   output logic             wfull,
   output logic             walmost_full,
   input  logic             rinc,
   output logic [DSIZE-1:0] rdata,
   output logic             rempty,
   output logic             ralmost_empty,
   output logic [ASIZE:0]   count,
   output logic             overflow,
   output logic             underflow
);

   localparam int unsigned DEPTH = 1 << ASIZE;
   localparam logic [ASIZE:0] DEPTH_C  = (ASIZE+1)'(DEPTH);
   localparam logic [ASIZE:0] AFULL_C  = (ASIZE+1)'(AFULL_TH);
   localparam logic [ASIZE:0] AEMPTY_C = (ASIZE+1)'(AEMPTY_TH);

   logic [DSIZE-1:0] r_mem [DEPTH];
   logic [ASIZE:0]   r_wbin;
   logic [ASIZE:0]   r_rbin;
   logic [ASIZE:0]   r_count;
   logic             r_wfull;
   logic             r_rempty;
   logic             r_afull;
   logic             r_aempty;
   logic             r_ovf;
   logic             r_udf;

   logic             w_wacc;
   logic             w_racc;
   logic [ASIZE-1:0] w_waddr;
   logic [ASIZE-1:0] w_raddr;
   logic [ASIZE:0]   w_count_next;

   assign w_wacc  = winc & ~r_wfull;
   assign w_racc  = rinc & ~r_rempty;
   assign w_waddr = r_wbin[ASIZE-1:0];
   assign w_raddr = r_rbin[ASIZE-1:0];

   // Next occupancy: a simultaneous accepted write and read leaves it unchanged
   always_comb begin
      w_count_next = r_count;
      case ({w_wacc, w_racc})
         2'b10:   w_count_next = r_count + 1'b1;
         2'b01:   w_count_next = r_count - 1'b1;
         default: w_count_next = r_count;
      endcase
   end

   // Storage array; never cleared, and writes are blocked during reset
   always_ff @(posedge clk) begin
      if (w_wacc && !rst) begin
         r_mem[w_waddr] <= wdata;
      end
   end

   // Pointers, occupancy and flags, all registered from the next count
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wbin   <= '0;
         r_rbin   <= '0;
         r_count  <= '0;
         r_wfull  <= 1'b0;
         r_rempty <= 1'b1;
         r_afull  <= 1'b0;
         r_aempty <= 1'b1;
      end else begin
         if (w_wacc) r_wbin <= r_wbin + 1'b1;
         if (w_racc) r_rbin <= r_rbin + 1'b1;
         r_count  <= w_count_next;
         r_wfull  <= (w_count_next == DEPTH_C);
         r_rempty <= (w_count_next == '0);
         r_afull  <= (w_count_next >= AFULL_C);
         r_aempty <= (w_count_next <= AEMPTY_C);
      end
   end

   // Sticky error flags; refused requests set them until reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (winc && r_wfull)  r_ovf <= 1'b1;
         if (rinc && r_rempty) r_udf <= 1'b1;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is presented combinationally from the read address
         always_comb begin
            rdata = r_mem[w_raddr];
         end
      end else begin : g_reg
         logic [DSIZE-1:0] r_rdata;
         // Registered read: loaded only when a read is accepted
         always_ff @(posedge clk) begin
            if (rst) begin
               r_rdata <= '0;
            end else if (w_racc) begin
               r_rdata <= r_mem[w_raddr];
            end
         end
         assign rdata = r_rdata;
      end
   endgenerate

   // Pointer distance must always equal the tracked occupancy
   a_ptr_count : assert property (@(posedge clk) disable iff (rst)
      ((r_wbin - r_rbin) == r_count));

   assign wfull         = r_wfull;
   assign walmost_full  = r_afull;
   assign rempty        = r_rempty;
   assign ralmost_empty = r_aempty;
   assign count         = r_count;
   assign overflow      = r_ovf;
   assign underflow     = r_udf;

endmodule

// File: doc/fifo2_sync.md
# fifo2_sync

Single-clock, parametrised successor to the dual-clock FIFO in the FPU datapath. It buffers DSIZE-bit words between producer and consumer stages that share one clock. Over the basic full/empty FIFO it adds:
- a selectable first-word-fall-through read mode;
- an occupancy count with programmable almost-full and almost-empty thresholds;
- sticky overflow and underflow error flags.

## Interface
Parameters:
- DSIZE, 8, data word width
- ASIZE, 4, address bits; DEPTH = 1<<ASIZE words
- FWFT, 0, read mode: 0 = registered read (1-cycle latency), 1 = first-word-fall-through
- AFULL_TH, (1<<ASIZE)-2, walmost_full asserts when count >= AFULL_TH; legal 1..DEPTH
- AEMPTY_TH, 2, ralmost_empty asserts when count <= AEMPTY_TH; legal 0..DEPTH-1

Ports (clk, rst first):
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset; synchronous and active-high
- wdata  in  DSIZE  write data
- winc  in  1  write request
- wfull  out  1  FIFO holds DEPTH words
- walmost_full  out  1  count >= AFULL_TH
- rinc  in  1  read request
- rdata  out  DSIZE  read data
- rempty  out  1  FIFO holds 0 words
- ralmost_empty  out  1  count <= AEMPTY_TH
- count  out  ASIZE+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while wfull
- underflow  out  1  sticky: a read was attempted while rempty

## Operation
- Storage: DEPTH x DSIZE register array, written on clk when a write is accepted. Memory is not cleared by rst.
- Pointers: binary wbin and rbin, ASIZE+1 bits. Address = low ASIZE bits. Both wrap DEPTH-1 -> 0 naturally.
- Write accepted (wacc) = winc & ~wfull. Read accepted (racc) = rinc & ~rempty. Both use the current registered flags.
- Count next value:
  - count+1 if wacc & ~racc
  - count-1 if racc & ~wacc
  - unchanged otherwise, including simultaneous accept
- Flags: wfull, rempty, walmost_full and ralmost_empty are registers loaded from count_next, so they are valid in the same cycle as count.
- Simultaneous winc and rinc when full: only the read is accepted. The write is refused and sets overflow.
- Simultaneous winc and rinc when empty: only the write is accepted. The read is refused and sets underflow.
- overflow is set on winc & wfull; underflow is set on rinc & rempty. Each stays set until rst.
- FWFT=0:
  - rdata is a register loaded with mem[raddr] on racc.
  - rdata holds its value on all other cycles.
- FWFT=1:
  - rdata = mem[raddr] combinationally, so the head word is presented whenever ~rempty.
  - racc consumes that word.
  - rdata is don't-care while rempty.
- Reset (rst high at an edge) forces:
  - wbin = rbin = 0, count = 0
  - rempty = 1, wfull = 0
  - walmost_full = 0, ralmost_empty = 1
  - overflow = underflow = 0
  - rdata register = 0 (FWFT=0)
- Reset mid-operation discards all contents. Requests sampled in the reset cycle are ignored and do not set the sticky flags.

## Timing
- Write at edge N (FIFO was empty):
  - count = 1 and rempty = 0 after edge N.
  - FWFT=1: rdata shows the word in cycle N+1.
- FWFT=0 read: racc at edge N -> rdata valid after edge N. Read latency is 1 cycle from rinc sampled.
- Full: after the DEPTH-th accepted write, wfull = 1 from the next cycle. One accepted read clears it after the following edge.
- Throughput: one write and one read per cycle sustained when neither full nor empty.
- No combinational path from winc/rinc to any flag output. With FWFT=1, the only combinational output is rdata (from raddr).

## Test plan
- Reset: hold rst for 2 cycles while toggling winc/rinc. Required after release: count=0, rempty=1, wfull=0, ralmost_empty=1, overflow=underflow=0, rdata=0 (FWFT=0).
- Fill/drain, DSIZE=8, ASIZE=4, FWFT=0: write 0x00..0x0F.
  - wfull=1 after the 16th write.
  - walmost_full=1 from count=14.
  - Read 16: rdata sequence 0x00..0x0F, each 1 cycle after rinc.
  - rempty=1 after the last read.
- FWFT=1: write 0xA5 into the empty FIFO; rdata=0xA5 with rempty=0 one cycle later, before any rinc. rinc then gives rempty=1.
- Simultaneous: at count=5, assert winc+rinc for 20 cycles with incrementing data. Required: count stays 5, data order preserved across pointer wrap.
- Errors:
  - Write while full: overflow=1 and the contents are unchanged (drain still returns the original 16).
  - Read while empty: underflow=1 and count stays 0.
  - Both flags persist until rst.
- Reset mid-operation: at count=9, assert rst for 1 cycle. Required: count=0 and rempty=1. A subsequent write of 0x3C reads back as 0x3C.
